// File: rtl/text_console_pkg.sv
`default_nettype none
// ============================================================================
// Module      : text_console_pkg
// Description : Shared state encoding, control codes and cell-width helper
//               for the text console controller.
// Revision    : 1.0
// ============================================================================
package text_console_pkg;

  typedef enum logic [1:0] {
    S_CLR_ALL  = 2'd0,
    S_IDLE     = 2'd1,
    S_WRITE    = 2'd2,
    S_CLR_LINE = 2'd3
  } state_e;

  localparam logic [7:0] c_bs    = 8'h08;
  localparam logic [7:0] c_lf    = 8'h0A;
  localparam logic [7:0] c_ff    = 8'h0C;
  localparam logic [7:0] c_cr    = 8'h0D;
  localparam logic [7:0] c_space = 8'h20;
  localparam logic [7:0] c_tilde = 8'h7E;

  function automatic int cell_width(input int ascii_w, input int color_w);
    return ascii_w + 2 * color_w;
  endfunction

endpackage : text_console_pkg
`default_nettype wire

// File: rtl/text_console_ctrl_blink.sv
`default_nettype none
// ============================================================================
// Module      : cursor_blink
// Description : Cursor blink phase generator; restart forces the cursor
//               visible for a full half-period.
// Revision    : 1.0
// ============================================================================
module cursor_blink #(
  parameter int BLINK_CYCLES = 12500000
) (
  input  logic clk_pix,
  input  logic rst,
  input  logic restart_i,
  output logic cursor_on_o
);

  localparam int c_cnt_w = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(BLINK_CYCLES - 1);

  logic [c_cnt_w-1:0] cnt_q;
  logic               on_q;

  always_ff @(posedge clk_pix) begin
    if (rst || restart_i) begin
      cnt_q <= '0;
      on_q  <= 1'b1;
    end else if (cnt_q == c_last) begin
      cnt_q <= '0;
      on_q  <= ~on_q;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cursor_on_o = on_q;

endmodule : cursor_blink
`default_nettype wire

// File: rtl/text_console_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : text_console_ctrl
// Description : Character-stream to cell-memory console controller with
//               cursor tracking, scrolling and screen/line clearing.
// Revision    : 1.0
// ============================================================================
module text_console_ctrl
  import text_console_pkg::*;
#(
  parameter int GRID_COL     = 80,
  parameter int GRID_ROW     = 43,
  parameter int ADDR_WIDTH   = 12,
  parameter int ASCII_WIDTH  = 8,
  parameter int COLOR_WIDTH  = 4,
  parameter int SCROLL_MODE  = 1,
  parameter int BLINK_CYCLES = 12500000
) (
  input  logic                                            clk_pix,
  input  logic                                            rst,
  input  logic                                            in_valid,
  input  logic [ASCII_WIDTH-1:0]                          in_ascii,
  input  logic [COLOR_WIDTH-1:0]                          color_fg,
  input  logic [COLOR_WIDTH-1:0]                          color_bg,
  output logic                                            in_ready,
  output logic                                            mem_we,
  output logic [ADDR_WIDTH-1:0]                           mem_addr,
  output logic [cell_width(ASCII_WIDTH, COLOR_WIDTH)-1:0] mem_data,
  output logic [$clog2(GRID_ROW)-1:0]                     top_row,
  output logic [$clog2(GRID_ROW)-1:0]                     cur_row,
  output logic [$clog2(GRID_COL)-1:0]                     cur_col,
  output logic                                            cursor_on
);

  localparam int c_row_w  = $clog2(GRID_ROW);
  localparam int c_col_w  = $clog2(GRID_COL);
  localparam int c_data_w = cell_width(ASCII_WIDTH, COLOR_WIDTH);

  localparam logic [c_row_w-1:0]    c_last_row  = c_row_w'(GRID_ROW - 1);
  localparam logic [c_col_w-1:0]    c_last_col  = c_col_w'(GRID_COL - 1);
  localparam logic [ADDR_WIDTH-1:0] c_last_cell = ADDR_WIDTH'(GRID_COL * GRID_ROW - 1);
  localparam logic [ADDR_WIDTH-1:0] c_line_len  = ADDR_WIDTH'(GRID_COL);
  localparam logic [ADDR_WIDTH-1:0] c_line_last = ADDR_WIDTH'(GRID_COL - 1);

  localparam logic [ASCII_WIDTH-1:0] c_bs_a    = ASCII_WIDTH'(c_bs);
  localparam logic [ASCII_WIDTH-1:0] c_lf_a    = ASCII_WIDTH'(c_lf);
  localparam logic [ASCII_WIDTH-1:0] c_ff_a    = ASCII_WIDTH'(c_ff);
  localparam logic [ASCII_WIDTH-1:0] c_cr_a    = ASCII_WIDTH'(c_cr);
  localparam logic [ASCII_WIDTH-1:0] c_space_a = ASCII_WIDTH'(c_space);
  localparam logic [ASCII_WIDTH-1:0] c_tilde_a = ASCII_WIDTH'(c_tilde);

  state_e                   state_q, state_d;
  logic [c_col_w-1:0]       col_q, col_d;
  logic [c_row_w-1:0]       row_q, row_d;
  logic [c_row_w-1:0]       top_q, top_d;
  logic [c_row_w-1:0]       phys_q, phys_d;
  logic [ADDR_WIDTH-1:0]    base_q, base_d;
  logic [ADDR_WIDTH-1:0]    cnt_q, cnt_d;
  logic [COLOR_WIDTH-1:0]   fg_q, fg_d;
  logic [COLOR_WIDTH-1:0]   bg_q, bg_d;
  logic                     clr_pend_q, clr_pend_d;
  logic                     we_q, we_d;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic [c_data_w-1:0]      data_q, data_d;

  logic accept;
  logic printable;
  logic newline;

  assign accept    = in_valid && (state_q == S_IDLE);
  assign printable = (in_ascii >= c_space_a) && (in_ascii <= c_tilde_a);

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      state_q <= S_CLR_ALL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_CLR_ALL:  if (cnt_q == c_last_cell) state_d = S_IDLE;
      S_IDLE:     if (accept) state_d = (in_ascii == c_ff_a) ? S_CLR_ALL : S_WRITE;
      S_WRITE:    state_d = clr_pend_q ? S_CLR_LINE : S_IDLE;
      S_CLR_LINE: if (cnt_q == c_line_last) state_d = S_IDLE;
      default:    state_d = S_CLR_ALL;
    endcase
  end

  always_comb begin
    col_d      = col_q;
    row_d      = row_q;
    top_d      = top_q;
    phys_d     = phys_q;
    base_d     = base_q;
    cnt_d      = cnt_q;
    fg_d       = fg_q;
    bg_d       = bg_q;
    clr_pend_d = clr_pend_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    newline    = 1'b0;

    unique case (state_q)
      S_CLR_ALL: begin
        we_d   = 1'b1;
        addr_d = cnt_q;
        data_d = {bg_q, fg_q, c_space_a};
        cnt_d  = (cnt_q == c_last_cell) ? '0 : cnt_q + 1'b1;
      end
      S_CLR_LINE: begin
        we_d   = 1'b1;
        addr_d = base_q + cnt_q;
        data_d = {bg_q, fg_q, c_space_a};
        cnt_d  = (cnt_q == c_line_last) ? '0 : cnt_q + 1'b1;
      end
      S_WRITE: begin
        cnt_d      = '0;
        clr_pend_d = 1'b0;
      end
      S_IDLE: begin
        if (accept) begin
          fg_d = color_fg;
          bg_d = color_bg;
          if (printable) begin
            we_d   = 1'b1;
            addr_d = base_q + ADDR_WIDTH'(col_q);
            data_d = {color_bg, color_fg, in_ascii};
            if (col_q == c_last_col) begin
              col_d   = '0;
              newline = 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end else begin
            case (in_ascii)
              c_cr_a: col_d = '0;
              c_lf_a: newline = 1'b1;
              c_bs_a: begin
                if (col_q != '0) begin
                  col_d  = col_q - 1'b1;
                  we_d   = 1'b1;
                  addr_d = base_q + ADDR_WIDTH'(col_q - 1'b1);
                  data_d = {color_bg, color_fg, c_space_a};
                end
              end
              c_ff_a: begin
                col_d      = '0;
                row_d      = '0;
                top_d      = '0;
                phys_d     = '0;
                base_d     = '0;
                cnt_d      = '0;
                clr_pend_d = 1'b0;
              end
              default: ;
            endcase
          end
        end
      end
      default: ;
    endcase

    // Line base follows the physical row incrementally so no multiplier is needed.
    if (newline) begin
      if (row_q != c_last_row || SCROLL_MODE != 0) begin
        if (row_q != c_last_row) begin
          row_d = row_q + 1'b1;
        end else begin
          top_d      = (top_q == c_last_row) ? '0 : top_q + 1'b1;
          clr_pend_d = 1'b1;
        end
        phys_d = (phys_q == c_last_row) ? '0 : phys_q + 1'b1;
        base_d = (phys_q == c_last_row) ? '0 : base_q + c_line_len;
      end else begin
        row_d      = '0;
        phys_d     = '0;
        base_d     = '0;
        clr_pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      col_q      <= '0;
      row_q      <= '0;
      top_q      <= '0;
      phys_q     <= '0;
      base_q     <= '0;
      cnt_q      <= '0;
      fg_q       <= '0;
      bg_q       <= '0;
      clr_pend_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      top_q      <= top_d;
      phys_q     <= phys_d;
      base_q     <= base_d;
      cnt_q      <= cnt_d;
      fg_q       <= fg_d;
      bg_q       <= bg_d;
      clr_pend_q <= clr_pend_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end

  cursor_blink #(
    .BLINK_CYCLES (BLINK_CYCLES)
  ) u_blink (
    .clk_pix     (clk_pix),
    .rst         (rst),
    .restart_i   (accept),
    .cursor_on_o (cursor_on)
  );

  assign in_ready = (state_q == S_IDLE);
  assign mem_we   = we_q;
  assign mem_addr = addr_q;
  assign mem_data = data_q;
  assign top_row  = top_q;
  assign cur_row  = row_q;
  assign cur_col  = col_q;

endmodule : text_console_ctrl
`default_nettype wire

// File: tb/tb_text_console_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_text_console_ctrl
// Description : Directed self-checking bench for text_console_ctrl (4x3 grid).
// Revision    : 1.0
// ============================================================================
module tb_text_console_ctrl;

  localparam int GC = 4;
  localparam int GR = 3;
  localparam int AW = 4;
  localparam int BC = 5;

  logic        clk_pix = 1'b0;
  logic        rst     = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_ascii = 8'h00;
  logic [3:0]  color_fg = 4'h0;
  logic [3:0]  color_bg = 4'h0;
  logic        in_ready;
  logic        mem_we;
  logic [3:0]  mem_addr;
  logic [15:0] mem_data;
  logic [1:0]  top_row;
  logic [1:0]  cur_row;
  logic [1:0]  cur_col;
  logic        cursor_on;

  int vectors = 0;
  int errs    = 0;
  logic [19:0] wlog[$];

  text_console_ctrl #(
    .GRID_COL(GC), .GRID_ROW(GR), .ADDR_WIDTH(AW), .ASCII_WIDTH(8),
    .COLOR_WIDTH(4), .SCROLL_MODE(1), .BLINK_CYCLES(BC)
  ) dut (
    .clk_pix(clk_pix), .rst(rst), .in_valid(in_valid), .in_ascii(in_ascii),
    .color_fg(color_fg), .color_bg(color_bg), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .top_row(top_row), .cur_row(cur_row), .cur_col(cur_col), .cursor_on(cursor_on)
  );

  always #5 clk_pix = ~clk_pix;

  always @(negedge clk_pix) begin
    if (mem_we) wlog.push_back({mem_addr, mem_data});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge clk_pix);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_log(input int idx, input logic [3:0] addr, input logic [15:0] data);
    logic [31:0] got;
    got = (idx < wlog.size()) ? {12'h0, wlog[idx]} : 32'hFFFF_FFFF;
    check($sformatf("log[%0d]", idx), got, {12'h0, addr, data});
  endtask

  task automatic check_sweep(input string tag, input int first, input int count, input logic [15:0] data);
    check({tag, "_count"}, 32'(wlog.size()), 32'(count));
    for (int i = 0; i < count; i++) check_log(i, 4'(first + i), data);
  endtask

  task automatic wait_ready(input int limit);
    int n = 0;
    while (!in_ready && n < limit) begin
      tick();
      n++;
    end
    check("ready_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic send(input logic [7:0] ch, input logic [3:0] fg, input logic [3:0] bg);
    wait_ready(200);
    in_valid = 1'b1;
    in_ascii = ch;
    color_fg = fg;
    color_bg = bg;
    tick();
    in_valid = 1'b0;
    wait_ready(200);
  endtask

  task automatic cursor(input string tag, input int t, input int r, input int c);
    check({tag, "_top"}, 32'(top_row), 32'(t));
    check({tag, "_row"}, 32'(cur_row), 32'(r));
    check({tag, "_col"}, 32'(cur_col), 32'(c));
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_data", 32'(mem_data), 32'd0);
    check("rst_blink", 32'(cursor_on), 32'd1);
    cursor("rst", 0, 0, 0);

    // Power-up clear: 12 cells of 0x0020
    rst = 1'b0;
    wlog.delete();
    wait_ready(100);
    check_sweep("boot_clr", 0, 12, 16'h0020);

    // Single 'A' fg=F bg=1
    wlog.delete();
    send(8'h41, 4'hF, 4'h1);
    check("A_count", 32'(wlog.size()), 32'd1);
    check_log(0, 4'd0, 16'h1F41);
    cursor("A", 0, 0, 1);

    // Form feed clears everything with its own colours, cursor home
    wlog.delete();
    send(8'h0C, 4'h0, 4'h0);
    check_sweep("ff_clr", 0, 12, 16'h0020);
    cursor("ff", 0, 0, 0);

    // ABCDE: wrap at col 3 moves E to row 1
    wlog.delete();
    send(8'h41, 4'h0, 4'h0);
    send(8'h42, 4'h0, 4'h0);
    send(8'h43, 4'h0, 4'h0);
    send(8'h44, 4'h0, 4'h0);
    send(8'h45, 4'h0, 4'h0);
    check("abcde_count", 32'(wlog.size()), 32'd5);
    check_log(3, 4'd3, 16'h0044);
    check_log(4, 4'd4, 16'h0045);
    cursor("abcde", 0, 1, 1);

    // Three LFs from row 0: scroll on the third, line cleared with LF colours
    send(8'h0C, 4'h0, 4'h0);
    wlog.delete();
    send(8'h0A, 4'h2, 4'h3);
    send(8'h0A, 4'h2, 4'h3);
    check("lf2_count", 32'(wlog.size()), 32'd0);
    cursor("lf2", 0, 2, 0);
    send(8'h0A, 4'h2, 4'h3);
    check_sweep("scroll_clr", 0, 4, 16'h3220);
    cursor("lf3", 1, 2, 0);
    wlog.delete();
    send(8'h58, 4'h0, 4'h0);
    check("X_count", 32'(wlog.size()), 32'd1);
    check_log(0, 4'd0, 16'h0058);
    cursor("X", 1, 2, 1);

    // CR, BS at col 0, then Z and BS
    wlog.delete();
    send(8'h0D, 4'h0, 4'h0);
    cursor("cr", 1, 2, 0);
    send(8'h08, 4'h0, 4'h0);
    check("bs0_count", 32'(wlog.size()), 32'd0);
    cursor("bs0", 1, 2, 0);
    send(8'h5A, 4'h5, 4'h6);
    cursor("Z", 1, 2, 1);
    send(8'h08, 4'h7, 4'h8);
    check("bs_count", 32'(wlog.size()), 32'd2);
    check_log(0, 4'd0, 16'h655A);
    check_log(1, 4'd0, 16'h8720);
    cursor("bs", 1, 2, 0);

    // Ignored code restarts blink: on for 5 cycles, then toggles every 5
    wlog.delete();
    wait_ready(10);
    in_valid = 1'b1;
    in_ascii = 8'h01;
    tick();
    in_valid = 1'b0;
    check("blink_accept", 32'(cursor_on), 32'd1);
    repeat (4) tick();
    check("blink_hold", 32'(cursor_on), 32'd1);
    tick();
    check("blink_off", 32'(cursor_on), 32'd0);
    repeat (5) tick();
    check("blink_on", 32'(cursor_on), 32'd1);
    check("ignored_count", 32'(wlog.size()), 32'd0);
    cursor("ignored", 1, 2, 0);

    // Printable wrap on last row: d at addr 3, then scroll clears row phys 1
    wlog.delete();
    send(8'h61, 4'h1, 4'h2);
    send(8'h62, 4'h1, 4'h2);
    send(8'h63, 4'h1, 4'h2);
    send(8'h64, 4'h1, 4'h2);
    check("wrap_count", 32'(wlog.size()), 32'd8);
    check_log(0, 4'd0, 16'h2161);
    check_log(3, 4'd3, 16'h2164);
    check_log(4, 4'd4, 16'h2120);
    check_log(7, 4'd7, 16'h2120);
    cursor("wrap", 2, 2, 0);

    // Reset during a line clear restarts the full-screen sweep from 0
    wait_ready(10);
    in_valid = 1'b1;
    in_ascii = 8'h0A;
    color_fg = 4'h0;
    color_bg = 4'h0;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    check("midclr_we", 32'(mem_we), 32'd1);
    rst = 1'b1;
    wlog.delete();
    repeat (2) tick();
    check("midrst_we", 32'(mem_we), 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    wait_ready(100);
    check_sweep("rst_clr", 0, 12, 16'h0020);
    cursor("rst_clr", 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule : tb_text_console_ctrl
`default_nettype wire

// File: doc/text_console_ctrl.md
TEXT_CONSOLE_CTRL -- requirements
Module: text_console_ctrl

Interface
REQ-001 Parameter GRID_COL, default 80, meaning character columns per row.
REQ-002 Parameter GRID_ROW, default 43, meaning character rows on screen.
REQ-003 Parameter ADDR_WIDTH, default 12, meaning cell-memory address width; SHALL satisfy 2^ADDR_WIDTH >= GRID_COL*GRID_ROW.
REQ-004 Parameter ASCII_WIDTH, default 8, meaning character code width.
REQ-005 Parameter COLOR_WIDTH, default 4, meaning width of each colour index.
REQ-006 Parameter SCROLL_MODE, default 1, meaning 1 = hardware scroll, 0 = wrap to top row.
REQ-007 Parameter BLINK_CYCLES, default 12500000, meaning clk_pix cycles per cursor blink half-period.
REQ-008 clk_pix  in  1  pixel clock, the only clock.
REQ-009 rst  in  1  synchronous active-high reset.
REQ-010 in_valid  in  1  character offered.
REQ-011 in_ascii  in  ASCII_WIDTH  character code.
REQ-012 color_fg / color_bg  in  COLOR_WIDTH each  colours for written cells, sampled at acceptance.
REQ-013 in_ready  out  1  controller can accept a character.
REQ-014 mem_we  out  1  cell-memory write strobe.
REQ-015 mem_addr  out  ADDR_WIDTH  cell address.
REQ-016 mem_data  out  ASCII_WIDTH+2*COLOR_WIDTH  {bg, fg, ascii}.
REQ-017 top_row  out  clog2(GRID_ROW)  physical row shown at screen top.
REQ-018 cur_row / cur_col  out  clog2(GRID_ROW) / clog2(GRID_COL)  logical cursor position.
REQ-019 cursor_on  out  1  blink phase for cursor rendering.

Function
REQ-020 States: CLR_ALL, IDLE, WRITE, CLR_LINE; a character is accepted only when in_valid && in_ready; in_ready SHALL be 1 only in IDLE.
REQ-021 Accepted char in cycle N -> registered mem_we/mem_addr/mem_data valid in cycle N+1 (WRITE); in_ready returns high no earlier than N+2.
REQ-022 Physical row = (top_row + cur_row) mod GRID_ROW; mem_addr = phys_row*GRID_COL + cur_col, produced by an incrementally maintained line-base register, no runtime multiplier.
REQ-023 Printable 0x20-0x7E: write cell, cur_col+1; at cur_col = GRID_COL-1, col wraps to 0 and a newline (REQ-026) follows.
REQ-024 0x0D (CR): cur_col = 0, no write.
REQ-025 0x08 (BS): if cur_col > 0, cur_col-1 and write 0x20 there; at cur_col = 0, no movement, no write.
REQ-026 0x0A (LF): if cur_row < GRID_ROW-1, cur_row+1; else SCROLL_MODE=1: top_row+1 mod GRID_ROW, cur_row unchanged; SCROLL_MODE=0: cur_row = 0; in both last-row cases enter CLR_LINE.
REQ-027 CLR_LINE writes 0x20 with latched colours to all GRID_COL cells of the new cursor line, one per cycle, col 0 first, then IDLE.
REQ-028 0x0C (FF): enter CLR_ALL; cursor and top_row = 0.
REQ-029 CLR_ALL writes 0x20 to addresses 0..GRID_COL*GRID_ROW-1 ascending, one per cycle, then IDLE.
REQ-030 Any other code accepted and ignored; no write, no cursor change.
REQ-031 cursor_on toggles every BLINK_CYCLES cycles; forced to 1 for BLINK_CYCLES cycles after each accepted character.
REQ-032 mem_we SHALL never assert with mem_addr >= GRID_COL*GRID_ROW.

Reset
REQ-033 On rst: state CLR_ALL, in_ready 0, mem_we 0, mem_addr 0, mem_data 0, top_row 0, cur_row 0, cur_col 0, cursor_on 1, blink counter 0, colours 0.
REQ-034 rst mid-operation aborts any clear or write; the clear restarts from address 0 after rst deasserts.

Structure
REQ-035 Package text_console_pkg holds the state enum, control-code constants (BS, LF, FF, CR, SPACE) and the cell-data width function.
REQ-036 Sub-module cursor_blink (counter, toggle, restart input) is instantiated once; all other logic sits in text_console_ctrl.

Verification
REQ-037 Reset, GRID_COL=4, GRID_ROW=3 -> 12 writes of 0x20 to addresses 0..11, then in_ready=1.
REQ-038 Send 'A' fg=0xF bg=0x1 -> one write addr 0, data 0x1F41, cur_col=1.
REQ-039 (4x3) Send 'ABCDE' -> E at addr 4, cur_row=1, cur_col=1.
REQ-040 (4x3, SCROLL_MODE=1) 3 LFs from row 0 -> top_row=1, cur_row=2, addresses 0..3 cleared; next 'X' at addr 0.
REQ-041 BS at col 0 -> no write; 'Z', BS -> 0x20 written at addr of Z, cur_col restored.
REQ-042 rst asserted during CLR_LINE -> clear restarts at addr 0, full 12-cell sweep, no stray writes.
